slave_decode: RTL and testbench

- Bus-side front end of an xregs register slave; sits directly upstream of the registered read-data mux.
- Accepts single-beat read/write requests over a valid/ready handshake and decodes the word address into one-hot word selects.
- Issues a one-cycle read request (rd_req + rd_words) or write strobe (wr_words + wr_data).
- Returns the mux's registered read data, or a write/decode-error status, on a valid/ready response channel.

---
 rtl/xregs_pkg.sv | 25 ++
 rtl/slave_decode.sv | 135 +++++++++++++
 tb/tb_slave_decode.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/xregs_pkg.sv
// Shared types and helpers for the xregs register slave front end.
package xregs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRsp
    } state_t;

    // Width of the onehot() result; callers slice off the low W_CNT bits.
    localparam int unsigned MaxWords = 64;

    localparam logic RspOk  = 1'b0;
    localparam logic RspErr = 1'b1;

    function automatic logic [MaxWords-1:0] onehot(input int unsigned idx, input int unsigned cnt);
        logic [MaxWords-1:0] res;
        res = '0;
        if (idx < cnt && idx < MaxWords) begin
            res[idx] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/slave_decode.sv
// Bus-side request decoder for the xregs slave: handshake, word decode, strobes and response.
// Optional write protection via RO_MASK is enabled by defining SLAVE_DECODE_WR_PROTECT_EN.
module slave_decode
    import xregs_pkg::*;
#(
    parameter int unsigned       W_WIDTH   = 32,
    parameter int unsigned       W_CNT     = 5,
    parameter int unsigned       A_WIDTH   = 8,
    parameter int unsigned       BASE_ADDR = 0,
    parameter logic [W_CNT-1:0]  RO_MASK   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [W_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_err,
    output logic [W_WIDTH-1:0] rsp_rdata,
    output logic               rd_req,
    output logic [W_CNT-1:0]   rd_words,
    input  logic [W_WIDTH-1:0] rd_data,
    output logic [W_CNT-1:0]   wr_words,
    output logic [W_WIDTH-1:0] wr_data
);

    localparam int unsigned IdxW = (W_CNT > 1) ? $clog2(W_CNT) : 1;
    localparam int unsigned AW1  = A_WIDTH + 1;

    state_t               state_q, state_d;
    logic                 req_ready_q;
    logic                 write_q;
    logic                 in_range_q;
    logic                 err_q, err_d;
    logic [IdxW-1:0]      idx_q;
    logic [W_WIDTH-1:0]   wdata_q;

    logic [AW1-1:0]       idx_full;
    logic                 in_range;
    logic                 accept;
    logic [MaxWords-1:0]  sel_full;
    logic [W_CNT-1:0]     sel;
    logic                 protect_hit;
    logic                 unused_sel_hi;

    // Extra top bit catches addresses below BASE_ADDR instead of letting them wrap into range.
    assign idx_full = {1'b0, req_addr} - AW1'(BASE_ADDR);
    assign in_range = !idx_full[A_WIDTH] && (idx_full < AW1'(W_CNT));
    assign accept   = (state_q == StIdle) && req_ready_q && req_valid;

    assign sel_full      = onehot({{(32 - IdxW){1'b0}}, idx_q}, W_CNT);
    assign sel           = sel_full[W_CNT-1:0];
    assign unused_sel_hi = ^sel_full[MaxWords-1:W_CNT];

`ifdef SLAVE_DECODE_WR_PROTECT_EN
    assign protect_hit = write_q && |(sel & RO_MASK);
`else
    logic unused_ro_mask;
    assign unused_ro_mask = ^RO_MASK;
    assign protect_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        rd_req    = 1'b0;
        rd_words  = '0;
        wr_words  = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                err_d = (!in_range_q || protect_hit) ? RspErr : RspOk;
                if (in_range_q && !write_q) begin
                    rd_req   = 1'b1;
                    rd_words = sel;
                end
                if (in_range_q && write_q && !protect_hit) begin
                    wr_words = sel;
                end
                state_d = StRsp;
            end
            StRsp: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                // Read mux holds its registered output until the next rd_req, so this stays stable.
                if (err_q == RspOk && !write_q) begin
                    rsp_rdata = rd_data;
                end
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            write_q     <= 1'b0;
            in_range_q  <= 1'b0;
            err_q       <= RspOk;
            idx_q       <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            // Registered ready keeps req_ready low while in reset and mirrors the IDLE state after.
            req_ready_q <= (state_d == StIdle);
            err_q       <= err_d;
            if (accept) begin
                write_q    <= req_write;
                in_range_q <= in_range;
                idx_q      <= idx_full[IdxW-1:0];
                if (req_write) begin
                    wdata_q <= req_wdata;
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign wr_data   = wdata_q;

endmodule

// File: tb/tb_slave_decode.sv
// Scoreboard bench for slave_decode with a small model of the downstream read mux.
module tb_slave_decode;

    localparam int unsigned WW   = 32;
    localparam int unsigned WC   = 5;
    localparam int unsigned AW   = 8;
    localparam int unsigned BASE = 'h10;
    localparam logic [WC-1:0] ROM = 5'b00001;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_err;
    logic [WW-1:0] rsp_rdata;
    logic          rd_req;
    logic [WC-1:0] rd_words;
    logic [WW-1:0] rd_data = '0;
    logic [WC-1:0] wr_words;
    logic [WW-1:0] wr_data;

    logic [WW-1:0] mux_mem [WC];
    logic [WW-1:0] exp_mem [WC];
    exp_t          sb [$];
    int            total = 0;
    int            bad = 0;

    slave_decode #(
        .W_WIDTH   (WW),
        .W_CNT     (WC),
        .A_WIDTH   (AW),
        .BASE_ADDR (BASE),
        .RO_MASK   (ROM)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .rd_req    (rd_req),
        .rd_words  (rd_words),
        .rd_data   (rd_data),
        .wr_words  (wr_words),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Read mux / register model: registered read data, writes on one-hot strobe.
    always @(posedge clk) begin
        for (int i = 0; i < WC; i++) begin
            if (rd_req && rd_words[i]) rd_data <= mux_mem[i];
            if (wr_words[i]) mux_mem[i] <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                          input int hold);
        int          idx;
        bit          inr;
        bit          prot;
        logic [WC-1:0] exp_rd, exp_wr;
        exp_t        e;
        int          cnt;
        idx  = int'(addr) - int'(BASE);
        inr  = (idx >= 0) && (idx < int'(WC));
        prot = 1'b0;
`ifdef SLAVE_DECODE_WR_PROTECT_EN
        if (inr && wr && ROM[idx]) prot = 1'b1;
`endif
        exp_rd = (inr && !wr) ? WC'(1 << idx) : '0;
        exp_wr = (inr && wr && !prot) ? WC'(1 << idx) : '0;
        e.err   = !inr || prot;
        e.rdata = (inr && !wr) ? exp_mem[idx] : '0;
        if (exp_wr != 0) exp_mem[idx] = wd;

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        cnt = 0;
        while (!req_ready) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt > 20) begin
                check("req_ready_timeout", 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb.push_back(e);
        // Access cycle: strobes only here.
        check("acc_rd_req", 32'(rd_req), 32'(exp_rd != 0));
        check("acc_rd_words", 32'(rd_words), 32'(exp_rd));
        check("acc_wr_words", 32'(wr_words), 32'(exp_wr));
        check("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("acc_req_ready", 32'(req_ready), 32'd0);
        if (exp_wr != 0) check("acc_wr_data", wr_data, wd);
        @(posedge clk); #1;
        check("rsp_valid_n2", 32'(rsp_valid), 32'd1);
        check("rsp_no_strobe", 32'({rd_req, rd_words, wr_words}), 32'd0);
        // Backpressure with a competing request held on the bus.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = AW'(BASE);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_err", 32'(rsp_err), 32'(sb[0].err));
            check("bp_rdata", rsp_rdata, sb[0].rdata);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_rdata", rsp_rdata, e.rdata);
        end
        check("rsp_req_ready_lo", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        if (hold > 0) check("no_early_accept", 32'(rd_req), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < WC; i++) begin
            mux_mem[i] = 32'h1000 + i;
            exp_mem[i] = 32'h1000 + i;
        end
        mux_mem[2] = 32'hDEADBEEF;
        exp_mem[2] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_strobes", 32'({rd_req, rd_words, wr_words}), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 8'h12, '0, 0);
        do_req(1'b1, 8'h14, 32'h1234, 0);
        do_req(1'b0, 8'h14, '0, 0);
        do_req(1'b0, 8'h15, '0, 0);
        do_req(1'b0, 8'h0F, '0, 0);
        do_req(1'b1, 8'h15, 32'h55, 0);
        do_req(1'b0, 8'hFF, '0, 0);
        do_req(1'b0, 8'h00, '0, 0);
        do_req(1'b0, 8'h12, '0, 5);
        do_req(1'b1, 8'h11, 32'hCAFE_0001, 3);
        do_req(1'b0, 8'h11, '0, 0);

        // Reset during the access cycle.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h13;
        req_wdata = 32'h7777;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_strobe", 32'(wr_words), 32'b01000);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", 32'({rd_req, rd_words, wr_words}), 32'd0);
        check("midrst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_wr_data", wr_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 8'h12, '0, 0);

        // Protected word 0 write, then read back.
        do_req(1'b1, 8'h10, 32'hABCD, 0);
        do_req(1'b0, 8'h10, '0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
